rca_adder_arbiter: RTL

Round-robin arbiter and sequencer that shares one sequential `rca_adder` instance among several requesters. It accepts an operand pair from one requester at a time through a valid/ready handshake and drives the adder's operand inputs. It waits the adder's fixed latency, captures `out_sum_result`, and returns the sum to the winning requester through a held response handshake. The block sits between the requester logic and the adder datapath; the adder itself is instantiated outside this block.

---
 rtl/rca_adder_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/rca_adder_arbiter.sv
// Round-robin front end that time-shares one external rca_adder among NUM_REQ requesters.
// Operands are registered toward the adder, the sum is captured after ADD_LATENCY cycles and held until accepted.
module rca_adder_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 1,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]               resp_id,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_result,
    output logic                          busy
);

    // state | meaning
    // IDLE  | waiting for any req_valid; grant and launch operands on the same edge
    // WAIT  | adder latency countdown; sum captured when the counter reaches 1
    // RESP  | holding resp_valid/resp_data until the owner asserts resp_ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   cnt;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    int                 idx;

    // Search starts just past the previous winner so every holder is served within NUM_REQ grants.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            cnt        <= '0;
            add_a      <= '0;
            add_b      <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        add_a      <= req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        add_b      <= req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        resp_id    <= gnt_idx;
                        last_grant <= gnt_idx;
                        cnt        <= CNT_W'(ADD_LATENCY);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        resp_data  <= add_result;
                        resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << resp_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[resp_id]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
